// File: rtl/mux_scan.sv
// mux_scan: registered N:1 channel multiplexer with an auto-scan sequencer.
// A channel is picked from a packed input bus, either by direct select
// (load/sel_in) or by stepping through all channels with a fixed dwell per
// channel. Output data, channel index, valid, wrap and err are registered.
module mux_scan #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      enable,
    input  logic                      mode,
    input  logic                      load,
    input  logic [SEL_W-1:0]          sel_in,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      valid,
    output logic                      wrap,
    output logic                      err
);

    // Dwell counter is one bit wider than strictly needed so DWELL=1 still
    // gets a legal non-zero width.
    localparam int CNT_W = $clog2(DWELL) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);
    // Channel count widened by one bit so an out-of-range sel_in can always
    // be detected, even when SEL_W is exactly clog2(CHANNELS).
    localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t              st_p1;
    state_t              st_nxt;

    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel_nxt;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                wrap_nxt;
    logic                err_nxt;

    logic                sel_in_ok;
    logic                load_ok;
    logic [WIDTH-1:0]    mux_data;

    logic [WIDTH-1:0]    dout_p1;
    logic [SEL_W-1:0]    sel_p1;
    logic                wrap_p1;
    logic                err_p1;

    assign sel_in_ok = ({1'b0, sel_in} < CH_LIM);
    assign load_ok   = load && sel_in_ok;

    // State register: remembers the operating mode of the previous cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_p1 <= HOLD;
        end else begin
            st_p1 <= st_nxt;
        end
    end

    // Next-state decode: the operating mode follows enable/mode directly.
    always_comb begin
        st_nxt = HOLD;
        if (enable) begin
            st_nxt = mode ? SCAN : MANUAL;
        end
    end

    // Sequencer control: next select, dwell count and event pulses.
    always_comb begin
        sel_nxt  = sel_q;
        cnt_nxt  = cnt_q;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        case (st_nxt)
            MANUAL: begin
                // Dwell count parked at zero so a later switch to scan
                // gives the current channel its full dwell.
                cnt_nxt = '0;
                if (load_ok) begin
                    sel_nxt = sel_in;
                end
            end
            SCAN: begin
                if (load_ok) begin
                    // A valid load overrides a coinciding dwell expiry.
                    sel_nxt = sel_in;
                    cnt_nxt = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    cnt_nxt = '0;
                    if (sel_q == SEL_LAST) begin
                        sel_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        sel_nxt = sel_q + SEL_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // HOLD: everything frozen, load ignored.
            end
        endcase
        if ((st_nxt != HOLD) && load && !sel_in_ok) begin
            err_nxt = 1'b1;
        end
    end

    // Channel mux: a compare per channel keeps the index always in range.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_q == SEL_W'(k)) begin
                mux_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    // Stage p1: sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            cnt_q   <= '0;
            wrap_p1 <= 1'b0;
            err_p1  <= 1'b0;
            dout_p1 <= '0;
            sel_p1  <= '0;
        end else begin
            sel_q   <= sel_nxt;
            cnt_q   <= cnt_nxt;
            wrap_p1 <= wrap_nxt;
            err_p1  <= err_nxt;
            if (enable) begin
                dout_p1 <= mux_data;
                sel_p1  <= sel_q;
            end
        end
    end

    // valid reflects whether the previous cycle was enabled.
    assign valid   = (st_p1 != HOLD);
    assign dout    = dout_p1;
    assign sel_out = sel_p1;
    assign wrap    = wrap_p1;
    assign err     = err_p1;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: directed scenarios plus random traffic, checked by a
// scoreboard against a scan-position reference model.
module tb_mux_scan;

    localparam int WIDTH    = 1;
    localparam int CHANNELS = 8;
    localparam int SEL_W    = 4;
    localparam int DWELL    = 4;
    localparam int PERIOD   = CHANNELS * DWELL;

    logic                      clk;
    logic                      rst_n;
    logic [CHANNELS*WIDTH-1:0] din;
    logic                      enable;
    logic                      mode;
    logic                      load;
    logic [SEL_W-1:0]          sel_in;
    logic [WIDTH-1:0]          dout;
    logic [SEL_W-1:0]          sel_out;
    logic                      valid;
    logic                      wrap;
    logic                      err;

    typedef struct {
        logic [WIDTH-1:0] dout;
        logic [SEL_W-1:0] sel;
        logic             valid;
        logic             wrap;
        logic             err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: position within the whole scan period.
    int               pos;
    logic [WIDTH-1:0] m_dout;
    logic [SEL_W-1:0] m_sel;

    mux_scan #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .DWELL(DWELL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .enable(enable), .mode(mode),
        .load(load), .sel_in(sel_in), .dout(dout), .sel_out(sel_out),
        .valid(valid), .wrap(wrap), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares the DUT against the oldest expectation after each edge.
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (dout !== e.dout || sel_out !== e.sel || valid !== e.valid ||
                wrap !== e.wrap || err !== e.err) begin
                errors++;
                $display("FAIL out t=%0t dout=%0h req %0h sel_out=%0d req %0d valid=%0b req %0b wrap=%0b req %0b err=%0b req %0b",
                         $time, dout, e.dout, sel_out, e.sel, valid, e.valid,
                         wrap, e.wrap, err, e.err);
            end
        end
    end

    task automatic model_reset();
        pos    = 0;
        m_dout = '0;
        m_sel  = '0;
    endtask

    // One clock cycle of stimulus; expected outputs after the edge are queued.
    task automatic cyc(input bit en, input bit md, input bit ld,
                       input logic [SEL_W-1:0] si,
                       input logic [CHANNELS*WIDTH-1:0] d);
        exp_t e;
        int   cur;
        int   npos;
        enable = en;
        mode   = md;
        load   = ld;
        sel_in = si;
        din    = d;
        e.valid = en;
        e.wrap  = 1'b0;
        e.err   = 1'b0;
        if (en) begin
            cur    = pos / DWELL;
            m_dout = d[cur*WIDTH +: WIDTH];
            m_sel  = SEL_W'(cur);
            if (ld && int'(si) < CHANNELS) begin
                pos = int'(si) * DWELL;
            end else begin
                if (ld) e.err = 1'b1;
                if (md) begin
                    npos = (pos + 1) % PERIOD;
                    if (npos == 0) e.wrap = 1'b1;
                    pos = npos;
                end else begin
                    pos = cur * DWELL;
                end
            end
        end
        e.dout = m_dout;
        e.sel  = m_sel;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (dout !== '0 || sel_out !== '0 || valid !== 1'b0 ||
            wrap !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s dout=%0h sel_out=%0d valid=%0b wrap=%0b err=%0b req all 0",
                     tag, dout, sel_out, valid, wrap, err);
        end
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, then releases.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_reset_outputs({tag, "_release"});
    endtask

    initial begin
        rst_n  = 1'b1;
        din    = '0;
        enable = 1'b0;
        mode   = 1'b0;
        load   = 1'b0;
        sel_in = '0;
        model_reset();
        @(posedge clk);
        #2;
        do_reset("reset");

        // Manual select over a fixed pattern, every channel in turn.
        for (int i = 0; i < CHANNELS; i++) begin
            cyc(1, 0, 1, SEL_W'(i), 8'hA5);
            cyc(1, 0, 0, '0, 8'hA5);
        end
        cyc(1, 0, 0, '0, 8'hA5);

        // Free-running scan from channel 0 across more than two periods.
        cyc(1, 0, 1, '0, 8'h3C);
        for (int i = 0; i < 2 * PERIOD + 6; i++) begin
            cyc(1, 1, 0, '0, 8'($urandom));
        end

        // Load to channel 2, let the dwell reach its last count, load 5.
        cyc(1, 1, 1, SEL_W'(2), 8'h5A);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, '0, 8'h5A);
        cyc(1, 1, 1, SEL_W'(5), 8'h5A);
        for (int i = 0; i < DWELL + 3; i++) cyc(1, 1, 0, '0, 8'($urandom));

        // Out-of-range load in manual mode at channel 3.
        cyc(1, 0, 1, SEL_W'(3), 8'h0F);
        cyc(1, 0, 0, '0, 8'h0F);
        cyc(1, 0, 1, SEL_W'(9), 8'h0F);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, '0, 8'h0F);

        // Hold mid-dwell on channel 6, then resume the scan.
        cyc(1, 1, 1, SEL_W'(6), 8'hC3);
        for (int i = 0; i < 2; i++) cyc(1, 1, 0, '0, 8'hC3);
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, SEL_W'(i), 8'($urandom));
        for (int i = 0; i < 2 * DWELL + 2; i++) cyc(1, 1, 0, '0, 8'($urandom));

        // Reset in the middle of a scan at channel 4.
        cyc(1, 1, 1, SEL_W'(4), 8'hFF);
        for (int i = 0; i < 2; i++) cyc(1, 1, 0, '0, 8'hFF);
        do_reset("reset_midscan");
        for (int i = 0; i < DWELL + 6; i++) cyc(1, 1, 0, '0, 8'($urandom));

        // Random traffic: all modes, loads in and out of range.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 6) == 0,
                SEL_W'($urandom % 16), 8'($urandom));
        end

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d req 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
